// File: rtl/score_pkg.sv
// Shared types and helpers for the two-player BCD score keeper.
// Optional input synchronizers are enabled in score_keeper by SCORE_SYNC_EN.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.tens = bcd_t'((v / 10) % 10);
    r.ones = bcd_t'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with synchronous clear, increment and
// saturation at 99; also exposes the incremented value for win compare.
module bcd_counter2
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [7:0] next
);

  bcd2_t nxt;

  always_comb begin
    nxt.tens = tens;
    nxt.ones = ones;
    if (ones == 4'd9) begin
      if (tens != 4'd9) begin
        nxt.tens = tens + 4'd1;
        nxt.ones = 4'd0;
      end
    end else begin
      nxt.ones = ones + 4'd1;
    end
  end

  assign next = nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      tens <= nxt.tens;
      ones <= nxt.ones;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: FSM, point edge detect, win compare.
// Define SCORE_SYNC_EN to add 2-flop input synchronizers.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] p1_tens,
  output logic [3:0] p1_ones,
  output logic [3:0] p2_tens,
  output logic [3:0] p2_ones,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam bcd2_t WIN_BCD = to_bcd2(WIN_SCORE);

  logic ng_s;
  logic p1_s;
  logic p2_s;

`ifdef SCORE_SYNC_EN
  logic [2:0] sync1;
  logic [2:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= {new_game, point_p2, point_p1};
      sync2 <= sync1;
    end
  end

  assign {ng_s, p2_s, p1_s} = sync2;
`else
  assign ng_s = new_game;
  assign p1_s = point_p1;
  assign p2_s = point_p2;
`endif

  state_t     state;
  state_t     state_nxt;
  logic       p1_q;
  logic       p2_q;
  logic       e1;
  logic       e2;
  logic       inc1;
  logic       inc2;
  logic       win1;
  logic       win2;
  logic [7:0] nxt1;
  logic [7:0] nxt2;

  // Edge registers run in every state so held levels never count later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q <= 1'b0;
      p2_q <= 1'b0;
    end else begin
      p1_q <= p1_s;
      p2_q <= p2_s;
    end
  end

  assign e1   = p1_s & ~p1_q;
  assign e2   = p2_s & ~p2_q;
  assign inc1 = (state == PLAY) & ~ng_s & e1 & ~e2;
  assign inc2 = (state == PLAY) & ~ng_s & e2 & ~e1;
  assign win1 = inc1 & (nxt1 == WIN_BCD);
  assign win2 = inc2 & (nxt2 == WIN_BCD);

  bcd_counter2 u_p1 (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ng_s),
    .inc  (inc1),
    .tens (p1_tens),
    .ones (p1_ones),
    .next (nxt1)
  );

  bcd_counter2 u_p2 (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ng_s),
    .inc  (inc2),
    .tens (p2_tens),
    .ones (p2_ones),
    .next (nxt2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ng_s) state_nxt = PLAY;
      PLAY: begin
        if (ng_s)             state_nxt = PLAY;
        else if (win1 | win2) state_nxt = OVER;
      end
      OVER: if (ng_s) state_nxt = PLAY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner <= WIN_NONE;
    end else begin
      unique case (1'b1)
        ng_s:    winner <= WIN_NONE;
        win1:    winner <= WIN_P1;
        win2:    winner <= WIN_P2;
        default: winner <= winner;
      endcase
    end
  end

  assign game_over = (state == OVER);

endmodule

// File: doc/score_keeper.md
# score_keeper

Two-player BCD score keeper for the pong game. It takes single-cycle-or-longer "point scored" strobes from the ball/paddle logic, keeps a two-digit BCD score per player, and detects the winning score. Its four 4-bit digit outputs drive the hex-to-seven-segment decoder instances directly.

## Interface
Parameters:
- WIN_SCORE, default 11: decimal winning score, legal range 1..99.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- new_game  in  1  level; clears both scores and enters PLAY.
- point_p1  in  1  player 1 scored; rising edge counts once.
- point_p2  in  1  player 2 scored; rising edge counts once.
- p1_tens, p1_ones  out  4  player 1 score as BCD digits (0..9 each).
- p2_tens, p2_ones  out  4  player 2 score as BCD digits (0..9 each).
- game_over  out  1  high in OVER state.
- winner  out  2  2'b00 none, 2'b01 player 1, 2'b10 player 2; 2'b11 never driven.

## Operation
- States:
  - IDLE: after reset; scores are held at 00; point inputs are ignored.
  - PLAY: scoring is active.
  - OVER: winning score has been reached.
- Transitions:
  - IDLE -> PLAY on new_game.
  - PLAY -> OVER when either score equals WIN_SCORE.
  - OVER -> PLAY on new_game.
  - new_game in PLAY: clear both scores, stay in PLAY.
- Edge detect: a point is `point_px & ~point_px_q`, where `point_px_q` is the previous sample. Holding an input high counts exactly once. The edge registers also update in IDLE and OVER, so a level held across a state change does not count.
- Increment rules:
  - ones 0..8 -> ones+1.
  - ones 9 -> ones 0 and tens+1.
  - At 99, the score saturates with no wrap.
- Simultaneous point_p1 and point_p2 edges in the same cycle: neither is scored; treated as a collision artifact.
- new_game asserted in the same cycle as a point edge: new_game wins, and the scores become 00.
- Win check: compare the incremented value to WIN_SCORE (converted to BCD at elaboration). game_over and winner are loaded on the same edge as the winning digit.
- In OVER: scores freeze, point inputs are ignored, and winner is held until new_game.
- Reset at any time, including mid-increment:
  - all digits = 0, game_over = 0, winner = 00.
  - state = IDLE.
  - edge registers = 0.

## Timing
- All outputs are registered. Reset values are listed above.
- Latency without SCORE_SYNC_EN:
  - point input first sampled high at edge k (low at k-1) -> digits updated at edge k, visible from cycle k+1.
  - game_over and winner follow the same timing.
- new_game sampled at edge k -> cleared digits and state PLAY visible from cycle k+1.
- Back-to-back points need the input low for at least one sampled edge between them. The maximum scoring rate is one point per 2 cycles per player.

## Configuration
- SCORE_SYNC_EN defined:
  - point_p1, point_p2 and new_game each pass through a 2-flop synchronizer before edge detect and state logic.
  - Latency is +2 cycles: a point sampled at edge k updates the digits at edge k+2.
  - Synchronizer flops reset to 0.
- SCORE_SYNC_EN undefined: inputs are assumed synchronous to clk and feed edge detect directly.

## Structure
- Package score_pkg holds:
  - state typedef (IDLE, PLAY, OVER);
  - winner encoding constants (WIN_NONE, WIN_P1, WIN_P2);
  - 4-bit BCD digit typedef;
  - helper function converting a 0..99 integer to a tens/ones BCD pair.
- Sub-module bcd_counter2: two-digit BCD counter with clr, inc and saturate-at-99; instanced once per player.
- Top level holds the FSM, edge detect, win compare and the optional synchronizers.

## Test plan
- Reset, then 3 point_p1 pulses without new_game -> digits stay 0/0/0/0, game_over = 0, winner = 00.
- new_game, then 10 single-cycle point_p1 pulses -> p1_tens = 1, p1_ones = 0, p2 = 00.
- new_game, point_p2 held high 5 cycles then low -> p2_ones = 1 only; coincident point_p1/point_p2 pulse -> no change; point pulse coincident with new_game -> scores 00.
- WIN_SCORE = 11, 11 point_p2 pulses -> on the 11th, p2 = 1/1, game_over = 1 and winner = 10 in the same cycle; a further point_p1 -> no change; new_game -> 00/00, game_over = 0, winner = 00.
- Assert rst_n low mid-game with p1 = 07, asynchronously between edges -> all outputs 0 immediately, state IDLE.
- With SCORE_SYNC_EN: point edge sampled at edge k -> digits change at edge k+2. Without it -> digits change at edge k.
